// File: rtl/fpu_pkg.sv
// Shared FPU type definitions: the decoded operation encoding passed from the
// FPU instruction decoder to the issue controller.
package fpu_pkg;

  typedef enum logic [4:0] {
    FPU_NOP,
    FPU_ADD,
    FPU_SUB,
    FPU_MUL,
    F_DIV,
    FPU_SQRT,
    FPU_FMADD,
    FPU_FMSUB,
    FPU_FNMADD,
    FPU_FNMSUB,
    F_SGNJ,
    F_SGNJ_N,
    F_SGNJ_X,
    FPU_MIN,
    FPU_MAX,
    FPU_CMP_EQ,
    FPU_CMP_LT,
    FPU_CMP_LE,
    FCLASS,
    FPU_MOVE_FLOAT2INT,
    FPU_MOVE_INT2FLOAT,
    FPU_FLOAT2INT,
    FPU_FLOAT2INT_U,
    FPU_INT2FLOAT,
    FPU_INT2FLOAT_U
  } fpu_op_e;

endpackage

// File: rtl/fpu_issue_ctrl.sv
// FPU issue/writeback controller: executes sign-inject, min/max, compare,
// classify and move locally, dispatches arithmetic ops, owns sticky fflags.
module fpu_issue_ctrl
  import fpu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  fpu_op_e     in_op_i,
  input  logic [2:0]  in_rm_i,
  input  logic [4:0]  in_rd_i,
  input  logic [31:0] in_a_i,
  input  logic [31:0] in_b_i,
  input  logic [31:0] in_c_i,
  output logic        arith_valid_o,
  output fpu_op_e     arith_op_o,
  output logic [2:0]  arith_rm_o,
  output logic [31:0] arith_a_o,
  output logic [31:0] arith_b_o,
  output logic [31:0] arith_c_o,
  input  logic        arith_done_i,
  input  logic [31:0] arith_result_i,
  input  logic [4:0]  arith_flags_i,
  output logic        arith_abort_o,
  output logic        wb_valid_o,
  input  logic        wb_ready_i,
  output logic [4:0]  wb_rd_o,
  output logic [31:0] wb_data_o,
  output logic        wb_to_int_o,
  output logic [4:0]  wb_flags_o,
  output logic [4:0]  fflags_o,
  input  logic        fflags_clr_i,
  output logic        busy_o
);

  // One-hot so arith_valid_o and wb_valid_o come straight off state flops.
  localparam logic [2:0] ST_IDLE  = 3'b001;
  localparam logic [2:0] ST_ARITH = 3'b010;
  localparam logic [2:0] ST_WB    = 3'b100;

  localparam int unsigned   CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0]   QNAN     = 32'h7FC0_0000;
  localparam logic [4:0]    FLAG_NV  = 5'b10000;

  function automatic logic is_local_op(input fpu_op_e op);
    case (op)
      F_SGNJ, F_SGNJ_N, F_SGNJ_X, FPU_MIN, FPU_MAX,
      FPU_CMP_EQ, FPU_CMP_LT, FPU_CMP_LE, FCLASS,
      FPU_MOVE_FLOAT2INT, FPU_MOVE_INT2FLOAT: return 1'b1;
      default:                                return 1'b0;
    endcase
  endfunction

  function automatic logic is_int_dest(input fpu_op_e op);
    case (op)
      FPU_CMP_EQ, FPU_CMP_LT, FPU_CMP_LE, FCLASS,
      FPU_MOVE_FLOAT2INT, FPU_FLOAT2INT, FPU_FLOAT2INT_U: return 1'b1;
      default:                                            return 1'b0;
    endcase
  endfunction

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  fpu_op_e          op_q, op_d;
  logic [2:0]       rm_q, rm_d;
  logic [4:0]       rd_q, rd_d;
  logic [31:0]      a_q, a_d, b_q, b_d, c_q, c_d;
  logic             to_int_q, to_int_d;
  logic [31:0]      wb_data_q, wb_data_d;
  logic [4:0]       wb_flags_q, wb_flags_d;
  logic [4:0]       fflags_q, fflags_d;
  logic             abort_q, abort_d;

  // Operand classification on the incoming operands (local ops resolve at accept).
  logic a_exp_max, a_exp_zero, a_man_nz, a_nan, a_snan, a_zero;
  logic b_nan, b_snan, b_zero;
  logic [31:0] key_a, key_b;
  logic a_lt_b, both_zero, any_nan, any_snan;
  logic [9:0] class_a;

  assign a_exp_max  = &in_a_i[30:23];
  assign a_exp_zero = ~|in_a_i[30:23];
  assign a_man_nz   = |in_a_i[22:0];
  assign a_nan      = a_exp_max & a_man_nz;
  assign a_snan     = a_nan & ~in_a_i[22];
  assign a_zero     = a_exp_zero & ~a_man_nz;
  assign b_nan      = (&in_b_i[30:23]) & (|in_b_i[22:0]);
  assign b_snan     = b_nan & ~in_b_i[22];
  assign b_zero     = ~|in_b_i[30:0];

  // Sign-magnitude to unsigned order key; -0 lands just below +0.
  assign key_a     = in_a_i[31] ? ~in_a_i : {1'b1, in_a_i[30:0]};
  assign key_b     = in_b_i[31] ? ~in_b_i : {1'b1, in_b_i[30:0]};
  assign a_lt_b    = key_a < key_b;
  assign both_zero = a_zero & b_zero;
  assign any_nan   = a_nan | b_nan;
  assign any_snan  = a_snan | b_snan;

  assign class_a = {a_nan & in_a_i[22],
                    a_snan,
                    ~in_a_i[31] & a_exp_max & ~a_man_nz,
                    ~in_a_i[31] & ~a_exp_zero & ~a_exp_max,
                    ~in_a_i[31] & a_exp_zero & a_man_nz,
                    ~in_a_i[31] & a_zero,
                     in_a_i[31] & a_zero,
                     in_a_i[31] & a_exp_zero & a_man_nz,
                     in_a_i[31] & ~a_exp_zero & ~a_exp_max,
                     in_a_i[31] & a_exp_max & ~a_man_nz};

  logic [31:0] local_data;
  logic [4:0]  local_flags;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no inferred latch).
    local_data  = '0;
    local_flags = '0;
    case (in_op_i)
      F_SGNJ:   local_data = {in_b_i[31], in_a_i[30:0]};
      F_SGNJ_N: local_data = {~in_b_i[31], in_a_i[30:0]};
      F_SGNJ_X: local_data = {in_a_i[31] ^ in_b_i[31], in_a_i[30:0]};
      FPU_MIN, FPU_MAX: begin
        local_flags = any_snan ? FLAG_NV : 5'b0;
        if (a_nan && b_nan)                        local_data = QNAN;
        else if (a_nan)                            local_data = in_b_i;
        else if (b_nan)                            local_data = in_a_i;
        else if ((in_op_i == FPU_MIN) == a_lt_b)   local_data = in_a_i;
        else                                       local_data = in_b_i;
      end
      FPU_CMP_EQ: begin
        local_data  = {31'b0, ~any_nan & ((in_a_i == in_b_i) | both_zero)};
        local_flags = any_snan ? FLAG_NV : 5'b0;
      end
      FPU_CMP_LT: begin
        local_data  = {31'b0, ~any_nan & a_lt_b & ~both_zero};
        local_flags = any_nan ? FLAG_NV : 5'b0;
      end
      FPU_CMP_LE: begin
        local_data  = {31'b0, ~any_nan & (a_lt_b | (in_a_i == in_b_i) | both_zero)};
        local_flags = any_nan ? FLAG_NV : 5'b0;
      end
      FCLASS:                                 local_data = {22'b0, class_a};
      FPU_MOVE_FLOAT2INT, FPU_MOVE_INT2FLOAT: local_data = in_a_i;
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    rm_d       = rm_q;
    rd_d       = rd_q;
    a_d        = a_q;
    b_d        = b_q;
    c_d        = c_q;
    to_int_d   = to_int_q;
    wb_data_d  = wb_data_q;
    wb_flags_d = wb_flags_q;
    abort_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid_i) begin
          op_d     = in_op_i;
          rm_d     = in_rm_i;
          rd_d     = in_rd_i;
          a_d      = in_a_i;
          b_d      = in_b_i;
          c_d      = in_c_i;
          to_int_d = is_int_dest(in_op_i);
          if (is_local_op(in_op_i)) begin
            wb_data_d  = local_data;
            wb_flags_d = local_flags;
            state_d    = ST_WB;
          end else if (in_op_i != FPU_NOP) begin
            cnt_d   = '0;
            state_d = ST_ARITH;
          end
        end
      end
      ST_ARITH: begin
        if (arith_done_i) begin
          wb_data_d  = arith_result_i;
          wb_flags_d = arith_flags_i;
          state_d    = ST_WB;
        end else if (TIMEOUT_CYCLES != 0 && cnt_q == CNT_LAST) begin
          wb_data_d  = QNAN;
          wb_flags_d = FLAG_NV;
          abort_d    = 1'b1;
          state_d    = ST_WB;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WB: if (wb_ready_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // A clear coinciding with a writeback leaves only that writeback's flags.
  logic wb_hs;
  assign wb_hs = state_q[2] & wb_ready_i;

  always_comb begin
    fflags_d = fflags_q;
    if (fflags_clr_i) fflags_d = wb_hs ? wb_flags_q : 5'b0;
    else if (wb_hs)   fflags_d = fflags_q | wb_flags_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      op_q       <= FPU_NOP;
      rm_q       <= '0;
      rd_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      c_q        <= '0;
      to_int_q   <= 1'b0;
      wb_data_q  <= '0;
      wb_flags_q <= '0;
      fflags_q   <= '0;
      abort_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      rm_q       <= rm_d;
      rd_q       <= rd_d;
      a_q        <= a_d;
      b_q        <= b_d;
      c_q        <= c_d;
      to_int_q   <= to_int_d;
      wb_data_q  <= wb_data_d;
      wb_flags_q <= wb_flags_d;
      fflags_q   <= fflags_d;
      abort_q    <= abort_d;
    end
  end

  assign in_ready_o    = (state_q == ST_IDLE);
  assign busy_o        = (state_q != ST_IDLE);
  assign arith_valid_o = state_q[1];
  assign arith_op_o    = op_q;
  assign arith_rm_o    = rm_q;
  assign arith_a_o     = a_q;
  assign arith_b_o     = b_q;
  assign arith_c_o     = c_q;
  assign arith_abort_o = abort_q;
  assign wb_valid_o    = state_q[2];
  assign wb_rd_o       = rd_q;
  assign wb_data_o     = wb_data_q;
  assign wb_to_int_o   = to_int_q;
  assign wb_flags_o    = wb_flags_q;
  assign fflags_o      = fflags_q;

endmodule
